eth_tx_axis_arbiter: RTL
========================

# eth_tx_axis_arbiter

Frame-granular arbiter that shares the tri-mode Ethernet MAC transmit AXIS port (`tx_axis_mac_*`) between up to four user AXIS sources. It runs in the `tx_mac_aclk` domain, between the user transmit logic and `tri_mode_ethernet_mac`. Arbitration is round-robin over whole frames, with a per-frame length guard that truncates runaway frames. A configurable idle gap separates consecutive grants.

## Interface

**Parameters**
- `C_NUM_PORTS`, default 2: number of requesters, legal range 2..4.
- `C_MAX_LEN`, default 1518: maximum bytes per frame forwarded to the MAC, range 64..65535.
- `C_GAP`, default 2: idle cycles inserted after each frame before the next grant, range 0..255.

**Ports**
- `tx_mac_aclk` in, 1: sole clock.
- `tx_mac_reset` in, 1: asynchronous, active-high reset.
- `s_axis_tvalid` in, C_NUM_PORTS: per-port valid.
- `s_axis_tdata` in, 8*C_NUM_PORTS: port i occupies bits [8i+7:8i].
- `s_axis_tlast` in, C_NUM_PORTS: per-port end of frame.
- `s_axis_tready` out, C_NUM_PORTS: per-port ready.
- `tx_axis_mac_tvalid` out, 1: to MAC.
- `tx_axis_mac_tdata` out, 8: to MAC.
- `tx_axis_mac_tlast` out, 1: to MAC.
- `tx_axis_mac_tready` in, 1: from MAC.
- `grant_id` out, 2: index of the current or last granted port.
- `busy` out, 1: high in XFER or DROP.
- `trunc_pulse` out, C_NUM_PORTS: one-cycle pulse on the port whose frame was truncated.

## Operation

**States:** IDLE, XFER, DROP, GAP.

**IDLE**
- Round-robin search begins at `rr_ptr+1` (mod C_NUM_PORTS). The first port with `s_axis_tvalid=1` wins.
- On a win, the FSM registers `grant_id`, sets `rr_ptr` to the winner, clears `byte_cnt`, and moves to XFER.
- With no requester, it stays in IDLE.

**XFER (combinational pass-through)**
- Outputs follow the granted port: `tx_axis_mac_tvalid = s_axis_tvalid[g]`, `tx_axis_mac_tdata = s_axis_tdata[g]`.
- Ready is passed back: `s_axis_tready[g] = tx_axis_mac_tready`. All other readies are 0.
- A beat is accepted when valid and ready are both high.
- On each accepted beat, `byte_cnt` (16-bit, saturating) increments.
- If an accepted beat has input tlast=1, the FSM moves to GAP, or to IDLE when C_GAP=0.
- If `byte_cnt == C_MAX_LEN-1` and the input tlast=0, the module forces `tx_axis_mac_tlast=1` on that beat. On acceptance it pulses `trunc_pulse[g]` and moves to DROP.

**DROP**
- Output tvalid is 0. `s_axis_tready[g]=1`, so remaining input beats are discarded.
- When an input beat with tlast=1 is accepted, the FSM moves to GAP, or to IDLE when C_GAP=0.

**GAP**
- Outputs are idle and all readies are 0.
- An 8-bit counter counts C_GAP cycles, then the FSM returns to IDLE.

**Boundary conditions**
- Simultaneous requests are resolved by `rr_ptr` only. A port that just finished has the lowest priority next time.
- Input tvalid dropping mid-frame in XFER leaves the grant held. There is no timeout.
- A single-beat frame (tlast on the first beat) is legal.
- A frame of exactly C_MAX_LEN bytes is not truncated, because its tlast comes from the input.

**Reset**
- Reset applies at any time, including mid-frame. The FSM returns to IDLE and `rr_ptr` goes to C_NUM_PORTS-1, so port 0 wins first.
- All outputs go to 0: `grant_id=0`, `busy=0`, `trunc_pulse=0`, all readies 0, MAC valid/tlast/data 0.
- A frame cut by reset is not completed on the MAC side.

## Timing
- Grant latency: input tvalid sampled in IDLE at edge n gives XFER at n+1. The first beat can be accepted in cycle n+1.
- Data path has zero latency: no register between input and MAC in XFER.
- Frame-to-frame spacing: the last accepted beat is followed by C_GAP GAP cycles plus 1 IDLE cycle before the next first beat.
- `trunc_pulse` is asserted in the cycle after the forced-tlast beat is accepted.
- `busy` is registered from the state.

## Configuration
- `ETH_TX_ARB_PRIO0_EN`
  - Defined: port 0 has strict priority. In IDLE, port 0 wins whenever its tvalid=1. Other ports are round-robin among themselves, and `rr_ptr` never selects port 0.
  - Undefined: plain round-robin across all ports, as described above.

## Test plan
- **Basic grant:** port 0 sends a 10-byte frame 0x5A..0x63 with tready=1. The MAC sees the same 10 bytes, tlast on 0x63, `grant_id=0`, and first beat 1 cycle after tvalid.
- **Round-robin fairness:** ports 0 and 1 request continuously with 4-byte frames and C_GAP=2. Grants alternate 0,1,0,1, with exactly 3 idle cycles between frames (without the macro).
- **Truncation:** C_MAX_LEN=64 and port 1 sends 100 bytes. The MAC receives 64 bytes with tlast on byte 64. `trunc_pulse[1]` fires once. Port 1's remaining 36 bytes are consumed with MAC tvalid=0.
- **Backpressure:** tready toggles 1,0,1,0 during a 10-byte frame. No byte is lost or duplicated, and `s_axis_tready` mirrors tready.
- **Reset mid-frame:** assert `tx_mac_reset` at byte 5 of a 10-byte frame. All outputs go to 0 immediately. After release, port 0 is granted first.
- **Priority macro:** with `ETH_TX_ARB_PRIO0_EN` defined, port 0 requests continuously against ports 1 and 2. Port 0 wins every arbitration in which it is valid.

Source files
------------

// File: rtl/eth_tx_axis_arbiter_if.sv
// Bundle of the user-side AXIS sources, the MAC transmit AXIS port and the arbiter status
// signals. The master modport is the arbiter's view; slave is the surrounding logic's view.
interface eth_tx_axis_arbiter_if #(
    parameter int C_NUM_PORTS = 2
);
    logic [C_NUM_PORTS-1:0]   s_axis_tvalid;
    logic [8*C_NUM_PORTS-1:0] s_axis_tdata;
    logic [C_NUM_PORTS-1:0]   s_axis_tlast;
    logic [C_NUM_PORTS-1:0]   s_axis_tready;

    logic                     tx_axis_mac_tvalid;
    logic [7:0]               tx_axis_mac_tdata;
    logic                     tx_axis_mac_tlast;
    logic                     tx_axis_mac_tready;

    logic [1:0]               grant_id;
    logic                     busy;
    logic [C_NUM_PORTS-1:0]   trunc_pulse;

    modport master (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        input  s_axis_tlast,
        output s_axis_tready,
        output tx_axis_mac_tvalid,
        output tx_axis_mac_tdata,
        output tx_axis_mac_tlast,
        input  tx_axis_mac_tready,
        output grant_id,
        output busy,
        output trunc_pulse
    );

    modport slave (
        output s_axis_tvalid,
        output s_axis_tdata,
        output s_axis_tlast,
        input  s_axis_tready,
        input  tx_axis_mac_tvalid,
        input  tx_axis_mac_tdata,
        input  tx_axis_mac_tlast,
        output tx_axis_mac_tready,
        input  grant_id,
        input  busy,
        input  trunc_pulse
    );
endinterface

// File: rtl/eth_tx_axis_arbiter.sv
// Frame-granular round-robin arbiter feeding the tri-mode MAC transmit AXIS port, with a
// per-frame length guard and idle gap. Define ETH_TX_ARB_PRIO0_EN to give port 0 strict priority.
module eth_tx_axis_arbiter #(
    parameter int C_NUM_PORTS = 2,
    parameter int C_MAX_LEN   = 1518,
    parameter int C_GAP       = 2
) (
    input  logic                  tx_mac_aclk,
    input  logic                  tx_mac_reset,
    eth_tx_axis_arbiter_if.master bus
);

    localparam logic [1:0]  LAST_PORT = 2'(C_NUM_PORTS - 1);
    localparam logic [15:0] LEN_LAST  = 16'(C_MAX_LEN - 1);
    localparam logic [7:0]  GAP_LAST  = (C_GAP > 0) ? 8'(C_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2,
        GAP  = 2'd3
    } state_t;

    // With no gap configured a finished frame goes straight back to arbitration.
    localparam state_t AFTER_FRAME = (C_GAP == 0) ? IDLE : GAP;

    state_t                 state;
    logic [1:0]             grant;
    logic [1:0]             rr_ptr;
    logic [15:0]            byte_cnt;
    logic [7:0]             gap_cnt;
    logic                   busy_q;
    logic [C_NUM_PORTS-1:0] trunc_q;

    logic                   sel_valid;
    logic                   sel_last;
    logic [7:0]             sel_data;
    logic [C_NUM_PORTS-1:0] grant_oh;
    logic                   force_last;
    logic                   xfer_acc;
    logic                   drop_acc;
    logic                   pick_found;
    logic [1:0]             pick_idx;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Returns {found, index}; the search starts one past the last winner.
    function automatic logic [2:0] rr_pick(input logic [C_NUM_PORTS-1:0] req,
                                           input logic [1:0]             ptr);
        logic       found;
        logic [1:0] win;
        int         idx;
        found = 1'b0;
        win   = 2'd0;
`ifdef ETH_TX_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k < C_NUM_PORTS; k++) begin
            idx = 1 + ((int'(ptr) - 1 + k) % (C_NUM_PORTS - 1));
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
`else
        for (int k = 1; k <= C_NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % C_NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
`endif
        return {found, win};
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'd0;
        grant_oh  = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (grant == 2'(i)) begin
                grant_oh[i] = 1'b1;
                sel_valid   = bus.s_axis_tvalid[i];
                sel_last    = bus.s_axis_tlast[i];
                sel_data    = bus.s_axis_tdata[8*i +: 8];
            end
        end
    end

    assign {pick_found, pick_idx} = rr_pick(bus.s_axis_tvalid, rr_ptr);

    // A beat that reaches the length limit without its own tlast gets one forced on it.
    assign force_last = (byte_cnt == LEN_LAST) && !sel_last;
    assign xfer_acc   = (state == XFER) && sel_valid && bus.tx_axis_mac_tready;
    assign drop_acc   = (state == DROP) && sel_valid;

    always_comb begin
        bus.tx_axis_mac_tvalid = 1'b0;
        bus.tx_axis_mac_tdata  = 8'd0;
        bus.tx_axis_mac_tlast  = 1'b0;
        bus.s_axis_tready      = '0;
        case (state)
            XFER: begin
                bus.tx_axis_mac_tvalid = sel_valid;
                bus.tx_axis_mac_tdata  = sel_data;
                bus.tx_axis_mac_tlast  = sel_valid && (sel_last || force_last);
                bus.s_axis_tready      = grant_oh & {C_NUM_PORTS{bus.tx_axis_mac_tready}};
            end
            DROP: begin
                bus.s_axis_tready = grant_oh;
            end
            default: ;
        endcase
    end

    assign bus.grant_id    = grant;
    assign bus.busy        = busy_q;
    assign bus.trunc_pulse = trunc_q;

    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            state    <= IDLE;
            grant    <= 2'd0;
            rr_ptr   <= LAST_PORT;
            byte_cnt <= 16'd0;
            gap_cnt  <= 8'd0;
            busy_q   <= 1'b0;
            trunc_q  <= '0;
        end else begin
            trunc_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_idx;
`ifdef ETH_TX_ARB_PRIO0_EN
                        if (pick_idx != 2'd0) begin
                            rr_ptr <= pick_idx;
                        end
`else
                        rr_ptr   <= pick_idx;
`endif
                        byte_cnt <= 16'd0;
                        busy_q   <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_acc) begin
                        byte_cnt <= sat_inc16(byte_cnt);
                        if (sel_last) begin
                            gap_cnt <= 8'd0;
                            busy_q  <= 1'b0;
                            state   <= AFTER_FRAME;
                        end else if (force_last) begin
                            trunc_q <= grant_oh;
                            state   <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (drop_acc && sel_last) begin
                        gap_cnt <= 8'd0;
                        busy_q  <= 1'b0;
                        state   <= AFTER_FRAME;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
